instr_fetch: RTL and testbench

Instruction fetch stage of the core. Sits between the instruction SRAM and decode: owns the program counter, issues word reads to the instruction memory, and buffers fetched {pc, instr} pairs in a small prefetch FIFO. Decode consumes them over a valid/ready handshake. Execute can redirect the stream, which flushes all buffered instructions and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0004;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            r_mem[r_wr_ptr] <= entry_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == CW'(DEPTH));
    assign head_o  = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, SRAM request logic, prefetch buffer to decode
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_redirect_pc;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (fetch_en_i)  w_state_next = RUN;
            RUN:     if (!fetch_en_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_pop         = instr_valid_o & instr_ready_i;
    // A full buffer may still accept a fetch when decode drains the head this cycle.
    assign w_push        = (r_state == RUN) & fetch_en_i & ~redirect_i & (~w_full | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc <= BOOT_ADDR;
        end else if (redirect_i) begin
            r_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign w_entry = '{pc: r_pc, instr: imem_rdata_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .entry_i (w_entry),
        .pop_i   (w_pop & ~redirect_i),
        .flush_i (redirect_i),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign imem_req_o    = w_push;
    assign imem_addr_o   = {2'b00, r_pc[31:2]};
    assign instr_valid_o = ~w_empty;
    assign instr_o       = w_head.instr;
    assign instr_pc_o    = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench with a queue-based fetch model checked every cycle
module tb_instr_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ready = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'd0;
    logic        req;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: program-order queue of {pc, instr}, fetch PC, running flag.
    logic [63:0] m_q [$];
    logic [31:0] m_pc  = BOOT;
    bit          m_run = 1'b0;
    logic [63:0] m_head;
    bit          m_pop;
    bit          m_req;

    assign rdata = mem[addr[5:0]];

    always #5 clk = ~clk;

    instr_fetch #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_en_i    (en),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_rdata_i  (rdata),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .instr_o       (instr),
        .instr_pc_o    (ipc),
        .redirect_i    (redir),
        .redirect_pc_i (rpc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_req();
        return rst_n && m_run && en && !redir &&
               ((m_q.size() < DEPTH) || (m_q.size() != 0 && ready));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_pc  = BOOT;
            m_run = 1'b0;
        end else begin
            m_pop = (m_q.size() != 0) && ready;
            m_req = model_req();
            if (redir) begin
                m_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_req) begin
                    m_q.push_back({m_pc, mem[m_pc[7:2]]});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = en;
        end
    end

    always @(negedge clk) begin
        m_head = (m_q.size() != 0) ? m_q[0] : 64'd0;
        check("valid", {31'd0, valid}, {31'd0, m_q.size() != 0});
        check("instr", instr, m_head[31:0]);
        check("instr_pc", ipc, m_head[63:32]);
        check("req", {31'd0, req}, {31'd0, model_req()});
        check("addr", addr, {2'b00, m_pc[31:2]});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
        for (int i = 1; i <= 4; i++) mem[i] = 32'h0000_0033;
        mem[5] = 32'h0030_2203;

        // Boot
        en = 1'b1; ready = 1'b1;
        step(2);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_addr", addr, 32'h1);
        check("rst_instr", instr, 32'd0);
        rst_n = 1'b1;
        step(1);
        check("boot_c1_valid", {31'd0, valid}, 32'd0);
        check("boot_c1_req", {31'd0, req}, 32'd1);
        step(1);
        for (int k = 0; k < 4; k++) begin
            check("boot_valid", {31'd0, valid}, 32'd1);
            check("boot_pc", ipc, 32'h4 + 32'(4 * k));
            check("boot_instr", instr, 32'h0000_0033);
            step(1);
        end
        check("boot_pc14", ipc, 32'h14);
        check("boot_instr14", instr, 32'h0030_2203);

        // Backpressure from boot
        rst_n = 1'b0; ready = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(6);
        check("bp_req", {31'd0, req}, 32'd0);
        check("bp_addr", addr, 32'h3);
        check("bp_head", ipc, 32'h4);
        ready = 1'b1;
        step(1);
        check("bp_resume1", ipc, 32'h8);
        step(1);
        check("bp_resume2", ipc, 32'hC);

        // Redirect
        redir = 1'b1; rpc = 32'h32;
        step(1);
        redir = 1'b0;
        check("rd_valid", {31'd0, valid}, 32'd0);
        check("rd_addr", addr, 32'hC);
        step(1);
        check("rd_head_pc", ipc, 32'h30);
        check("rd_head_instr", instr, 32'hA500_000C);

        // Enable drop with a full buffer
        ready = 1'b0;
        step(2);
        en = 1'b0; ready = 1'b1;
        step(1);
        check("en_drain1", ipc, 32'h34);
        check("en_addr1", addr, 32'hE);
        check("en_req1", {31'd0, req}, 32'd0);
        step(1);
        check("en_empty", {31'd0, valid}, 32'd0);
        check("en_addr2", addr, 32'hE);
        en = 1'b1;
        #1;
        check("en_idle_req", {31'd0, req}, 32'd0);
        step(1);
        check("en_run_req", {31'd0, req}, 32'd1);
        check("en_run_addr", addr, 32'hE);
        step(1);
        check("en_resume_pc", ipc, 32'h38);

        // Wrap
        redir = 1'b1; rpc = 32'hFFFF_FFFC;
        step(1);
        redir = 1'b0;
        check("wr_addr1", addr, 32'h3FFF_FFFF);
        step(1);
        check("wr_pc1", ipc, 32'hFFFF_FFFC);
        check("wr_instr1", instr, 32'hA500_003F);
        check("wr_addr2", addr, 32'h0);
        step(1);
        check("wr_pc2", ipc, 32'h0);
        check("wr_instr2", instr, 32'hA500_0000);

        // Asynchronous reset with a full buffer
        ready = 1'b0;
        step(3);
        check("ar_full_valid", {31'd0, valid}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, valid}, 32'd0);
        check("ar_req", {31'd0, req}, 32'd0);
        check("ar_addr", addr, 32'h1);
        check("ar_instr", instr, 32'd0);
        step(1);
        rst_n = 1'b1; ready = 1'b1;
        step(2);
        check("ar_restart_pc", ipc, 32'h4);
        check("ar_restart_instr", instr, 32'h0000_0033);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
